// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the fetch PC and picks the next PC from
// sequential fetch, EX branches, ID jumps and JR. A redirect that arrives during a stall is buffered.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] jump_pc4_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        pending_o,
  output logic        misalign_o,
  output logic [15:0] redirect_cnt_o
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state;
  logic [31:0] pend_tgt;
  logic        pend_is_br;

  logic [31:0] jump_tgt;
  logic        req_any;
  logic [31:0] req_tgt;
  logic        apply_en;
  logic [31:0] apply_tgt;
  logic        unused_pc4_lo;

  assign unused_pc4_lo = ^jump_pc4_i[27:0];
  assign jump_tgt      = {jump_pc4_i[31:28], jump_index_i, 2'b00};

  // The EX branch is the oldest instruction; ID requests behind it are on the wrong path.
  always_comb begin
    req_any = branch_i | jr_i | jump_i;
    req_tgt = jump_tgt;
    if (branch_i)  req_tgt = branch_target_i;
    else if (jr_i) req_tgt = jr_target_i;
  end

  // In HOLD only a fresh branch can displace the buffered target.
  always_comb begin
    apply_en  = !stall_i && ((state == HOLD) || req_any);
    apply_tgt = req_tgt;
    if (state == HOLD) apply_tgt = branch_i ? branch_target_i : pend_tgt;
  end

  assign flush_if_o = rst_i && apply_en;
  assign flush_id_o = rst_i && apply_en && (branch_i || ((state == HOLD) && pend_is_br));
  assign pc_plus4_o = pc_o + 32'd4;
  assign pending_o  = (state == HOLD);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= RUN;
      pc_o           <= RESET_PC;
      pend_tgt       <= 32'h0;
      pend_is_br     <= 1'b0;
      misalign_o     <= 1'b0;
      redirect_cnt_o <= 16'h0;
    end else begin
      if (apply_en) begin
        pc_o  <= apply_tgt;
        state <= RUN;
        if (apply_tgt[1:0] != 2'b00) misalign_o <= 1'b1;
        if (redirect_cnt_o != 16'hFFFF) redirect_cnt_o <= redirect_cnt_o + 16'd1;
      end else if (!stall_i) begin
        pc_o <= pc_plus4_o;
      end

      if (stall_i) begin
        if (state == RUN && req_any) begin
          state      <= HOLD;
          pend_tgt   <= req_tgt;
          pend_is_br <= branch_i;
        end else if (state == HOLD && branch_i) begin
          pend_tgt   <= branch_target_i;
          pend_is_br <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus random bench for pc_sequencer against a rule-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, br = 1'b0, jp = 1'b0, jr = 1'b0;
  logic [31:0] bt = '0, jrt = '0, jpc4 = '0;
  logic [25:0] jidx = '0;
  logic [31:0] pc, pc4;
  logic        fif, fid, pend, mis;
  logic [15:0] cnt;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_pc;
  logic        m_hold, m_isbr, m_mis;
  logic [31:0] m_buf;
  int          m_cnt;

  pc_sequencer dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_i(br), .branch_target_i(bt),
    .jump_i(jp), .jump_index_i(jidx), .jump_pc4_i(jpc4),
    .jr_i(jr), .jr_target_i(jrt),
    .pc_o(pc), .pc_plus4_o(pc4), .flush_if_o(fif), .flush_id_o(fid),
    .pending_o(pend), .misalign_o(mis), .redirect_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_hold = 1'b0; m_isbr = 1'b0; m_mis = 1'b0; m_buf = '0; m_cnt = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".pc"},   pc,   m_pc);
    chk({tag, ".pc4"},  pc4,  m_pc + 32'd4);
    chk({tag, ".pend"}, {31'b0, pend}, {31'b0, m_hold});
    chk({tag, ".mis"},  {31'b0, mis},  {31'b0, m_mis});
    chk({tag, ".cnt"},  {16'b0, cnt},  m_cnt);
  endtask

  task automatic clear_req();
    stall = 0; br = 0; jp = 0; jr = 0;
  endtask

  // Inputs already set mid-cycle: check strobes, clock once, update model, check registers.
  task automatic cycle(input string tag);
    logic        app, e_fif, e_fid;
    logic [31:0] tgt;
    app = 0; e_fif = 0; e_fid = 0; tgt = '0;
    if (!m_hold) begin
      if (br)      tgt = bt;
      else if (jr) tgt = jrt;
      else         tgt = {jpc4[31:28], jidx, 2'b00};
      if (!stall) begin
        app = br | jr | jp; e_fif = app; e_fid = br;
      end else if (br | jr | jp) begin
        m_hold = 1; m_buf = tgt; m_isbr = br;
      end
    end else if (stall) begin
      if (br) begin m_buf = bt; m_isbr = 1; end
    end else begin
      tgt = br ? bt : m_buf;
      app = 1; e_fif = 1; e_fid = m_isbr | br; m_hold = 0;
    end
    #1;
    chk({tag, ".fif"}, {31'b0, fif}, {31'b0, e_fif});
    chk({tag, ".fid"}, {31'b0, fid}, {31'b0, e_fid});
    @(posedge clk);
    if (app) begin
      m_pc = tgt;
      if (tgt[1:0] != 2'b00) m_mis = 1;
      if (m_cnt < 65535) m_cnt++;
    end else if (!stall) m_pc = m_pc + 32'd4;
    #1;
    chk_regs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1 chk_regs("reset");
    chk("reset.fif", {31'b0, fif}, 32'h0);

    // sequential fetch
    for (int i = 0; i < 4; i++) cycle("seq");
    chk("seq.pc16", pc, 32'h10);

    // J-type target
    jp = 1; jpc4 = 32'h1000_0040; jidx = 26'h0000100;
    cycle("jump");
    chk("jump.pc", pc, 32'h1000_0400);
    chk("jump.cnt", {16'b0, cnt}, 32'd1);
    clear_req();

    // branch beats jr
    br = 1; bt = 32'h80; jr = 1; jrt = 32'h200;
    cycle("br_jr");
    chk("br_jr.pc", pc, 32'h80);
    clear_req();

    // stalled jr, then branch overwrites, then release
    stall = 1; jr = 1; jrt = 32'h300; cycle("hold1");
    jr = 0; br = 1; bt = 32'h500;     cycle("hold2");
    br = 0; jr = 1;                   cycle("hold3");
    chk("hold.pend", {31'b0, pend}, 32'h1);
    stall = 0; jr = 1; jrt = 32'h700; cycle("release");
    chk("release.pc", pc, 32'h500);
    clear_req();
    cycle("after_rel");

    // misaligned target, then wrap
    br = 1; bt = 32'h0000_0102; cycle("mis");
    chk("mis.pc", pc, 32'h102);
    chk("mis.flag", {31'b0, mis}, 32'h1);
    bt = 32'hFFFF_FFFC; cycle("to_top");
    clear_req();
    chk("wrap.pc4", pc4, 32'h0);
    cycle("wrap");
    chk("wrap.pc", pc, 32'h0);
    chk("mis.sticky", {31'b0, mis}, 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 1) == 0);
      br = ($urandom_range(0, 3) == 0);
      jr = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 3) == 0);
      bt = $urandom; jrt = $urandom; jpc4 = $urandom; jidx = 26'($urandom);
      if ($urandom_range(0, 7) != 0) begin bt[1:0] = 2'b00; jrt[1:0] = 2'b00; end
      cycle("rand");
    end

    // async reset mid-HOLD
    clear_req();
    stall = 1; br = 1; bt = 32'h900; cycle("pre_rst");
    chk("pre_rst.pend", {31'b0, pend}, 32'h1);
    stall = 0; br = 1;
    #2 rst = 0;
    model_reset();
    #1;
    chk_regs("async_rst");
    chk("async_rst.fif", {31'b0, fif}, 32'h0);
    chk("async_rst.fid", {31'b0, fid}, 32'h0);
    clear_req();
    @(negedge clk); rst = 1;

    // counter saturation
    jp = 1; jpc4 = 32'h0; jidx = 26'h40;
    for (int i = 0; i < 65540; i++) cycle("sat");
    chk("sat.final", {16'b0, cnt}, 32'h0000_FFFF);
    clear_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the pipelined MIPS core. Owns the PC register and sequences next-PC selection among sequential fetch, taken branches (resolved in EX), J-type jumps (resolved in ID, 26-bit index shifted left two and merged with PC+4[31:28]), and jump-register. Handles fetch stalls by buffering a redirect that arrives during a stall. Emits the pipeline flush strobes and a redirect counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard unit holds fetch (PC and IF/ID frozen)
- branch_i  in  1  taken branch from EX stage
- branch_target_i  in  32  branch target from EX adder
- jump_i  in  1  J/JAL decoded in ID
- jump_index_i  in  26  instr[25:0] of the jump
- jump_pc4_i  in  32  PC+4 of the jump instruction (ID copy)
- jr_i  in  1  JR decoded in ID
- jr_target_i  in  32  forwarded rs value
- pc_o  out  32  current fetch PC
- pc_plus4_o  out  32  pc_o + 4, combinational
- flush_if_o  out  1  squash IF/ID register this cycle
- flush_id_o  out  1  squash ID/EX register this cycle
- pending_o  out  1  a buffered redirect is waiting
- misalign_o  out  1  sticky: a redirect target had bits[1:0] != 0
- redirect_cnt_o  out  16  saturating count of applied redirects

## Operation
- Jump target: {jump_pc4_i[31:28], jump_index_i, 2'b00}. All PC arithmetic modulo 2^32; pc_plus4_o wraps 32'hFFFF_FFFC -> 0.
- Request priority same cycle: branch_i > jr_i > jump_i (EX instruction is older; ID request is on wrong path).
- States: RUN, HOLD (pending redirect buffered in pend_tgt, pend_is_br).
- RUN, stall_i=0: redirect present -> PC <= selected target, flush_if_o=1, flush_id_o=1 iff branch; no redirect -> PC <= PC+4.
- RUN, stall_i=1: PC held; redirect present -> capture target and type, go HOLD; no flush strobes.
- HOLD, stall_i=1: PC held; new branch_i overwrites buffer (pend_is_br=1); jr_i/jump_i ignored (same stalled instruction re-asserting or wrong path).
- HOLD, stall_i=0: apply buffer (or a new branch_i, which takes priority over the buffer) -> PC <= target, flush_if_o=1, flush_id_o=pend_is_br or branch_i; go RUN. A new jr/jump in this cycle is ignored.
- misalign_o sets when any applied target has [1:0]!=0; target is still loaded unchanged; cleared only by reset.
- redirect_cnt_o increments by 1 on each applied redirect, saturates at 16'hFFFF.
- Reset (any time, including HOLD): pc_o=RESET_PC, state RUN, buffer cleared, pending_o=0, misalign_o=0, redirect_cnt_o=0; flush_if_o=flush_id_o=0 while in reset.

## Timing
- PC, state, buffer, misalign, counter registered on clk_i rising edge; async clear on rst_i low.
- flush_if_o, flush_id_o combinational from current state and inputs; asserted in the same cycle the redirect is applied, for exactly that cycle.
- Redirect latency: target on pc_o one cycle after the applying cycle.
- pending_o = (state == HOLD), registered.
- Reset deassertion: first fetch at RESET_PC in the first cycle; PC+4 at the next edge absent stall.

## Test plan
- Reset release, no requests, 4 cycles -> pc_o 0,4,8,12; flushes 0; redirect_cnt_o 0.
- jump_i=1, jump_pc4_i=32'h1000_0040, jump_index_i=26'h0000100 -> flush_if_o=1, flush_id_o=0 that cycle; next pc_o=32'h1000_0400; cnt=1.
- branch_i and jr_i same cycle, branch_target_i=32'h80, jr_target_i=32'h200 -> pc_o=32'h80 next, flush_if_o=flush_id_o=1.
- stall_i=1 for 3 cycles with jr_i=1 target 32'h300 in cycle 1, branch_i target 32'h500 in cycle 2 -> pc_o held, pending_o=1, no flush; stall drop -> flush both, pc_o=32'h500; jr lost.
- branch_target_i=32'h0000_0102 -> misalign_o=1 sticky, pc_o=32'h102; PC at 32'hFFFF_FFFC -> next 0.
- rst_i low mid-HOLD -> all outputs to reset values immediately (async); 65540 redirects -> redirect_cnt_o stays 16'hFFFF.
